// File: rtl/uart_rx_axis_fifo_if.sv
// AXI-Stream byte channel carrying received UART characters with an
// end-of-message marker.
interface uart_rx_axis_fifo_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;
    logic             last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/uart_rx_axis_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through FIFO exposed as an
// AXI-Stream master; end of message is declared after a line-idle timeout.
module uart_rx_axis_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 8,
    parameter int CLK_RATE   = 100000000,
    parameter int BAUD       = 115200,
    parameter int IDLE_CHARS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    uart_rx_axis_fifo_if.master  m_axis,
    output logic                 overflow,
    output logic                 frame_err
);
    localparam int CLKS_PER_BIT = CLK_RATE / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int TIMEOUT      = IDLE_CHARS * 10 * CLKS_PER_BIT;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int TO_W         = $clog2(TIMEOUT + 1);
    localparam int BIT_W        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int AW           = $clog2(DEPTH);

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_ONE      = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(WIDTH - 1);
    localparam logic [TO_W-1:0]  TO_ONE       = TO_W'(1);
    localparam logic [TO_W-1:0]  TO_END       = TO_W'(TIMEOUT - 1);
    localparam logic [AW:0]      PTR_ONE      = (AW + 1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    logic             rx_p0;
    logic             rx_p1;
    logic             rx_s;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [BIT_W-1:0] bit_idx_q;
    logic [BIT_W-1:0] bit_idx_d;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic             good_stop;
    logic             bad_stop;

    logic [WIDTH-1:0] pend_data_q;
    logic             pend_valid_q;
    logic [TO_W-1:0]  timer_q;
    logic             timer_run;
    logic             timeout;

    logic [WIDTH:0]   mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push_en;
    logic             wr_en;
    logic [WIDTH:0]   push_word;
    logic [WIDTH:0]   head;
    logic             overflow_q;
    logic             frame_err_q;

    // Stage p0/p1: two-flop synchroniser for the asynchronous line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= uart_rx;
            rx_p1 <= rx_p0;
        end
    end

    assign rx_s = rx_p1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        good_stop = 1'b0;
        bad_stop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF_END) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[WIDTH-1:1]};
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        good_stop = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        bad_stop = 1'b1;
                        state_d  = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The newest byte waits in pend until either another byte arrives
    // (so it is not last) or the line stays idle long enough (so it is).
    assign timer_run = (state_q == ST_IDLE) && pend_valid_q;
    assign timeout   = timer_run && (timer_q == TO_END);
    assign push_en   = (good_stop && pend_valid_q) || timeout;
    assign push_word = {timeout, pend_data_q};

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && m_axis.ready;
    assign wr_en = push_en && (!full || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            pend_valid_q <= 1'b0;
            timer_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            if (good_stop) begin
                pend_valid_q <= 1'b1;
            end else if (timeout) begin
                pend_valid_q <= 1'b0;
            end
            if (timer_run && !timeout) begin
                timer_q <= timer_q + TO_ONE;
            end else begin
                timer_q <= '0;
            end
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            overflow_q  <= push_en && full && !pop;
            frame_err_q <= bad_stop;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        if (good_stop) begin
            pend_data_q <= shift_q;
        end
        if (wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= push_word;
        end
    end

    // Outputs read the head entry directly; forced to zero while empty.
    assign head         = mem[rd_ptr_q[AW-1:0]];
    assign m_axis.valid = !empty;
    assign m_axis.data  = empty ? '0 : head[WIDTH-1:0];
    assign m_axis.last  = !empty && head[WIDTH];
    assign overflow     = overflow_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_uart_rx_axis_fifo.sv
// Directed bench for uart_rx_axis_fifo: table of single-byte messages plus
// hand-written sequences for back-to-back, overflow, framing, glitch, reset/wrap.
module tb_uart_rx_axis_fifo;
    localparam int CPB      = 16;
    localparam int CLK_RATE = 1600;
    localparam int BAUD     = 100;
    localparam int IDLE     = 2;
    localparam int TO       = IDLE * 10 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic uart_rx = 1'b1;
    logic overflow;
    logic frame_err;

    uart_rx_axis_fifo_if #(.WIDTH(8)) axis ();

    uart_rx_axis_fifo #(
        .WIDTH(8), .DEPTH(8), .CLK_RATE(CLK_RATE), .BAUD(BAUD), .IDLE_CHARS(IDLE)
    ) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .m_axis(axis),
        .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] q_data[$];
    logic       q_last[$];
    int         q_cyc[$];
    int         ovf_cnt = 0;
    int         ferr_cnt = 0;
    int         stable_err = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic       prev_last = 1'b0;
    bit         rand_rdy = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            if (axis.valid && axis.ready) begin
                q_data.push_back(axis.data);
                q_last.push_back(axis.last);
                q_cyc.push_back(cyc);
            end
            if (overflow) ovf_cnt <= ovf_cnt + 1;
            if (frame_err) ferr_cnt <= ferr_cnt + 1;
            if (prev_stall && axis.valid && (axis.data != prev_data || axis.last != prev_last))
                stable_err <= stable_err + 1;
            prev_stall <= axis.valid && !axis.ready;
            prev_data  <= axis.data;
            prev_last  <= axis.last;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            if (rand_rdy) axis.ready = ($urandom_range(0, 1) == 1);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, output int t_stop);
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(CPB);
        end
        t_stop = cyc;
        uart_rx = stop_ok;
        tick(CPB);
        uart_rx = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_valid"}, int'(axis.valid), 0);
        check({tag, "_data"}, int'(axis.data), 0);
        check({tag, "_last"}, int'(axis.last), 0);
        check({tag, "_overflow"}, int'(overflow), 0);
        check({tag, "_frame_err"}, int'(frame_err), 0);
        @(posedge clk);
        #2;
    endtask

    typedef struct {
        logic [7:0] b;
        bit         stop_ok;
        int         exp_beats;
        logic [7:0] exp_data;
        bit         exp_last;
        int         exp_ferr;
    } vec_t;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int t, n0, o0, f0, s0;
        logic [7:0] exp_b2b[3];
        logic [7:0] exp_b;

        vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 1'b1, 0};
        vecs[1] = '{8'h00, 1'b1, 1, 8'h00, 1'b1, 0};
        vecs[2] = '{8'hFF, 1'b1, 1, 8'hFF, 1'b1, 0};
        vecs[3] = '{8'h55, 1'b0, 0, 8'h00, 1'b0, 1};
        vecs[4] = '{8'h3C, 1'b1, 1, 8'h3C, 1'b1, 0};
        exp_b2b[0] = 8'h01;
        exp_b2b[1] = 8'h02;
        exp_b2b[2] = 8'h03;

        axis.ready = 1'b1;
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b1;
        tick(5);

        // Single-byte messages from the table
        for (int v = 0; v < 5; v++) begin
            n0 = q_data.size();
            o0 = ovf_cnt;
            f0 = ferr_cnt;
            send_byte(vecs[v].b, vecs[v].stop_ok, t);
            tick(TO + 40);
            check($sformatf("vec%0d_beats", v), q_data.size() - n0, vecs[v].exp_beats);
            check($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
            check($sformatf("vec%0d_ovf", v), ovf_cnt - o0, 0);
            if (vecs[v].exp_beats > 0) begin
                if (q_data.size() > n0) begin
                    check($sformatf("vec%0d_data", v), int'(q_data[n0]), int'(vecs[v].exp_data));
                    check($sformatf("vec%0d_last", v), int'(q_last[n0]), int'(vecs[v].exp_last));
                    check_rng($sformatf("vec%0d_latency", v), q_cyc[n0] - (t + CPB / 2), TO + 1, TO + 5);
                end else begin
                    check($sformatf("vec%0d_beat_present", v), q_data.size() - n0, 1);
                end
            end
        end

        // Back-to-back bytes form one message
        n0 = q_data.size();
        send_byte(8'h01, 1'b1, t);
        send_byte(8'h02, 1'b1, t);
        send_byte(8'h03, 1'b1, t);
        tick(TO + 40);
        check("b2b_beats", q_data.size() - n0, 3);
        for (int i = 0; i < 3; i++) begin
            if (q_data.size() > n0 + i) begin
                check($sformatf("b2b_data%0d", i), int'(q_data[n0 + i]), int'(exp_b2b[i]));
                check($sformatf("b2b_last%0d", i), int'(q_last[n0 + i]), (i == 2) ? 1 : 0);
            end
        end

        // Backpressure and overflow
        axis.ready = 1'b0;
        n0 = q_data.size();
        o0 = ovf_cnt;
        s0 = stable_err;
        for (int i = 0; i < 10; i++) send_byte(8'(8'h10 + i), 1'b1, t);
        tick(TO + 40);
        check("ovf_beats_stalled", q_data.size() - n0, 0);
        check("ovf_pulses", ovf_cnt - o0, 2);
        @(negedge clk);
        check("ovf_head_valid", int'(axis.valid), 1);
        check("ovf_head_data", int'(axis.data), 8'h10);
        @(posedge clk);
        #2;
        axis.ready = 1'b1;
        tick(20);
        check("ovf_stable", stable_err - s0, 0);
        check("ovf_drain_beats", q_data.size() - n0, 8);
        for (int i = 0; i < 8; i++) begin
            if (q_data.size() > n0 + i) begin
                check($sformatf("ovf_data%0d", i), int'(q_data[n0 + i]), 8'h10 + i);
                check($sformatf("ovf_last%0d", i), int'(q_last[n0 + i]), 0);
            end
        end
        check("ovf_pulses_after", ovf_cnt - o0, 2);

        // Framing error followed by a good frame
        n0 = q_data.size();
        f0 = ferr_cnt;
        send_byte(8'h55, 1'b0, t);
        tick(2 * CPB);
        send_byte(8'h66, 1'b1, t);
        tick(TO + 40);
        check("ferr_pulses", ferr_cnt - f0, 1);
        check("ferr_beats", q_data.size() - n0, 1);
        if (q_data.size() > n0) begin
            check("ferr_data", int'(q_data[n0]), 8'h66);
            check("ferr_last", int'(q_last[n0]), 1);
        end

        // Glitch shorter than half a bit is rejected
        n0 = q_data.size();
        f0 = ferr_cnt;
        uart_rx = 1'b0;
        tick(5);
        uart_rx = 1'b1;
        tick(4 * CPB);
        check("glitch_beats", q_data.size() - n0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        send_byte(8'h81, 1'b1, t);
        tick(TO + 40);
        check("glitch_next_beats", q_data.size() - n0, 1);
        if (q_data.size() > n0) begin
            check("glitch_next_data", int'(q_data[n0]), 8'h81);
            check("glitch_next_last", int'(q_last[n0]), 1);
        end

        // Reset in bit 4 of a frame while a byte is pending, then wrap test
        n0 = q_data.size();
        send_byte(8'h77, 1'b1, t);
        exp_b = 8'hC3;
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 5; i++) begin
            uart_rx = exp_b[i];
            tick((i == 4) ? CPB / 2 : CPB);
        end
        rst = 1'b0;
        tick(3);
        check_reset_outputs("midrst");
        uart_rx = 1'b1;
        rst = 1'b1;
        tick(2 * CPB);
        check("midrst_no_beat", q_data.size() - n0, 0);

        o0 = ovf_cnt;
        rand_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send_byte(8'(8'h40 + 7 * i), 1'b1, t);
            tick(TO + 20);
        end
        rand_rdy = 1'b0;
        axis.ready = 1'b1;
        tick(20);
        check("wrap_beats", q_data.size() - n0, 20);
        check("wrap_ovf", ovf_cnt - o0, 0);
        for (int i = 0; i < 20; i++) begin
            if (q_data.size() > n0 + i) begin
                check($sformatf("wrap_data%0d", i), int'(q_data[n0 + i]), (8'h40 + 7 * i) & 8'hFF);
                check($sformatf("wrap_last%0d", i), int'(q_last[n0 + i]), 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
